// File: rtl/bicc_pkg.sv
// Shared types and constants for the bitstream count sequencer.
// Holds the FSM state encoding and the accumulator width helper.
package bicc_pkg;

    localparam int BICC_MAX_WORD_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bicc_state_e;

    // Four guard bits cover (2^LEN_WIDTH - 1) words of up to eight ones each.
    function automatic int bicc_acc_width(input int len_width);
        return len_width + 4;
    endfunction

endpackage

// File: rtl/bitstream_count_sched_if.sv
// Word-source and result-sink handshakes of the bitstream count sequencer.
// master = environment side, slave = sequencer side.
interface bitstream_count_sched_if #(
    parameter int WORD_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_WIDTH-1:0]  in_data;
    logic                   res_valid;
    logic                   res_ready;
    logic [LEN_WIDTH+3:0]   res_count;
    logic                   res_hit;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_count, res_hit
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_count, res_hit
    );
endinterface

// File: rtl/bitstream_count_sched_popcount.sv
// Combinational ones counter for one bitstream word (up to eight bits).
// Built as a ripple chain of small adders, one stage per input bit.
module popcount
    import bicc_pkg::*;
#(
    parameter int INPUT_WIDTH = 8
) (
    input  logic [INPUT_WIDTH-1:0]                        i_data,
    output logic [$clog2(BICC_MAX_WORD_WIDTH+1)-1:0]      o_count
);
    localparam int CW = $clog2(BICC_MAX_WORD_WIDTH + 1);

    generate
        for (genvar gi = 0; gi < INPUT_WIDTH; gi++) begin : g_bit
            logic [CW-1:0] w_sum;
            if (gi == 0) begin : g_first
                assign w_sum = CW'(i_data[0]);
            end else begin : g_next
                assign w_sum = g_bit[gi-1].w_sum + CW'(i_data[gi]);
            end
        end
    endgenerate

    assign o_count = g_bit[INPUT_WIDTH-1].w_sum;

endmodule

// File: rtl/bitstream_count_sched.sv
// Streams bitstream words through a popcount and accumulates the ones over a job.
// Optional threshold compare is enabled by defining BICC_THRESH_EN.
module bitstream_count_sched
    import bicc_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  num_words,
    input  logic [LEN_WIDTH+3:0]  threshold,
    output logic                  busy,
    bitstream_count_sched_if.slave bus
);
    localparam int ACC_W = bicc_acc_width(LEN_WIDTH);
    localparam int PC_W  = $clog2(BICC_MAX_WORD_WIDTH + 1);

    bicc_state_e            r_state;
    logic [LEN_WIDTH-1:0]   r_words_left;
    logic [ACC_W-1:0]       r_acc;
    logic                   r_in_ready;
    logic                   r_res_valid;
    logic                   r_hit;

    logic [PC_W-1:0]        w_pc;
    logic [ACC_W-1:0]       w_acc_sum;
    logic                   w_start_ok;
    logic                   w_word_hs;
    logic                   w_last_word;
    logic                   w_hit_last;
    logic                   w_hit_zero;

    popcount #(
        .INPUT_WIDTH (WORD_WIDTH)
    ) u_popcount (
        .i_data  (bus.in_data),
        .o_count (w_pc)
    );

    assign w_start_ok  = (r_state == ST_IDLE) && start && !abort;
    assign w_word_hs   = r_in_ready && bus.in_valid && !abort;
    assign w_acc_sum   = r_acc + ACC_W'(w_pc);
    assign w_last_word = (r_words_left == LEN_WIDTH'(1));

`ifdef BICC_THRESH_EN
    logic [ACC_W-1:0] r_thresh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_thresh <= '0;
        end else if (w_start_ok) begin
            r_thresh <= threshold;
        end
    end

    // A zero-length job enters DONE with acc = 0, compared against the incoming threshold.
    assign w_hit_last = (w_acc_sum >= r_thresh);
    assign w_hit_zero = (threshold == '0);
`else
    logic w_unused_threshold;
    assign w_unused_threshold = ^threshold;
    assign w_hit_last = 1'b0;
    assign w_hit_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
            r_acc        <= '0;
            r_in_ready   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_hit        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                    if (w_start_ok) begin
                        r_words_left <= num_words;
                        r_acc        <= '0;
                        r_hit        <= 1'b0;
                        if (num_words != '0) begin
                            r_state    <= ST_RUN;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                            r_hit       <= w_hit_zero;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                    end else if (w_word_hs) begin
                        r_acc        <= w_acc_sum;
                        r_words_left <= r_words_left - LEN_WIDTH'(1);
                        if (w_last_word) begin
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_res_valid <= 1'b1;
                            r_hit       <= w_hit_last;
                        end
                    end
                end

                ST_DONE: begin
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_acc       <= '0;
                        r_res_valid <= 1'b0;
                        r_hit       <= 1'b0;
                    end else if (bus.res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_hit       <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    // Abort masks both handshakes in the same cycle so neither can complete.
    assign bus.in_ready  = r_in_ready && !abort;
    assign bus.res_valid = r_res_valid && !abort;
    assign bus.res_count = r_acc;
    assign bus.res_hit   = r_hit;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bitstream_count_sched.sv
// Self-checking bench for bitstream_count_sched: directed scenarios plus random jobs
// scored against a word-level ones-count model; honours BICC_THRESH_EN.
module tb_bitstream_count_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  num_words;
    logic [11:0] threshold;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit [7:0] words_q [0:255];

    bitstream_count_sched_if #(.WORD_WIDTH(8), .LEN_WIDTH(8)) bus ();

    bitstream_count_sched #(
        .WORD_WIDTH (8),
        .LEN_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .num_words (num_words),
        .threshold (threshold),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_hit(input int cnt, input int thr);
`ifdef BICC_THRESH_EN
        return (cnt >= thr);
`else
        return 1'b0;
`endif
    endfunction

    // One complete job: start, feed words_q[0..n-1] with random gaps, hold result, drain.
    task automatic run_job(input int n, input int thr, input int gap_pct, input int hold, input string tag);
        int  exp_cnt = 0;
        int  acc_n   = 0;
        int  cyc     = 0;
        bit  v;
        bit  rdy;
        start = 1'b1; num_words = 8'(n); threshold = 12'(thr);
        tick();
        start = 1'b0;
        check({tag, "_ready_after_start"}, 32'(bus.in_ready), 32'(n != 0));
        check({tag, "_valid_after_start"}, 32'(bus.res_valid), 32'(n == 0));
        while (acc_n < n && cyc < 4 * n + 40) begin
            v = ($urandom_range(99) >= gap_pct);
            bus.in_valid = v;
            bus.in_data  = words_q[acc_n];
            @(negedge clk);
            rdy = bus.in_ready;
            if (bus.res_valid !== 1'b0)
                check({tag, "_early_res_valid"}, 32'(bus.res_valid), 32'd0);
            tick();
            if (v && rdy) begin
                exp_cnt += $countones(words_q[acc_n]);
                acc_n++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_words_accepted"}, 32'(acc_n), 32'(n));
        if (gap_pct == 0)
            check({tag, "_cycles"}, 32'(cyc), 32'(n));
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_res_count"}, 32'(bus.res_count), 32'(exp_cnt));
        check({tag, "_res_hit"}, 32'(bus.res_hit), 32'(model_hit(exp_cnt, thr)));
        bus.res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
            check({tag, "_hold_count"}, 32'(bus.res_count), 32'(exp_cnt));
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(bus.res_valid), 32'd0);
        $display("job %s n=%0d thr=%0d count=%0d hit=%0b", tag, n, thr, exp_cnt, model_hit(exp_cnt, thr));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_words = '0; threshold = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_count", 32'(bus.res_count), 32'd0);
        check("rst_res_hit",   32'(bus.res_hit),   32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        rst = 1'b0;
        tick();

        // Scenario 1: fixed words, two thresholds straddling the count.
        words_q[0] = 8'hFF; words_q[1] = 8'h0F; words_q[2] = 8'h01; words_q[3] = 8'h00;
        run_job(4, 13, 0, 0, "s1_thr13");
        run_job(4, 14, 0, 0, "s1_thr14");

        // Zero-length job.
        run_job(0, 0, 0, 0, "s2_zero");

        // Gapped input and a held result.
        words_q[0] = 8'hA5; words_q[1] = 8'h80; words_q[2] = 8'h7E;
        run_job(3, 9, 60, 5, "s3_gaps");

        // Abort after two words, on a cycle with in_valid high.
        words_q[0] = 8'hFF; words_q[1] = 8'hFF;
        start = 1'b1; num_words = 8'd4; threshold = 12'd0;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hFF;
        repeat (2) tick();
        abort = 1'b1;
        #1;
        check("abort_in_ready_masked", 32'(bus.in_ready), 32'd0);
        tick();
        abort = 1'b0; bus.in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        $display("job abort_run after 2 words");
        words_q[0] = 8'h03;
        run_job(1, 2, 0, 0, "s4_after_abort");

        // Abort in DONE beats a same-cycle result handshake; start+abort in IDLE is ignored.
        start = 1'b1; num_words = 8'd0;
        tick();
        start = 1'b0;
        bus.res_ready = 1'b1; abort = 1'b1;
        #1;
        check("abort_done_valid_masked", 32'(bus.res_valid), 32'd0);
        tick();
        bus.res_ready = 1'b0; abort = 1'b0;
        check("abort_done_busy", 32'(busy), 32'd0);
        start = 1'b1; abort = 1'b1; num_words = 8'd5;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", 32'(busy), 32'd0);
        check("start_abort_idle_ready", 32'(bus.in_ready), 32'd0);
        $display("job abort_done and start_with_abort");

        // Maximum-length job of all ones.
        for (int i = 0; i < 256; i++) words_q[i] = 8'hFF;
        run_job(255, 2040, 0, 0, "s5_max");

        // Reset in the middle of a job.
        start = 1'b1; num_words = 8'd255; threshold = 12'd1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_res_count", 32'(bus.res_count), 32'd0);
        check("midrst_res_hit",   32'(bus.res_hit),   32'd0);
        check("midrst_busy",      32'(busy),          32'd0);
        rst = 1'b0; bus.in_valid = 1'b0;
        tick();
        $display("job midrst after 10 words");

        // Random jobs.
        for (int j = 0; j < 8; j++) begin
            n = $urandom_range(20);
            for (int i = 0; i < n; i++) words_q[i] = 8'($urandom);
            run_job(n, $urandom_range(90), $urandom_range(50), $urandom_range(3),
                    $sformatf("rnd%0d", j));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
